// File: rtl/csa_pkg.sv
// Shared definitions for the carry-select adder: default geometry,
// block-count helper and single-bit full-adder helpers used by the
// ripple blocks.
package csa_pkg;

    localparam int CSA_WIDTH_DEF = 8;
    localparam int CSA_BLOCK_DEF = 4;

    // Number of carry-select blocks for a given operand width and block width.
    function automatic int csa_num_blocks(input int width, input int block);
        return width / block;
    endfunction

    // Sum output of a single full adder.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry output of a single full adder (generate OR propagate-and-carry).
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

endpackage

// File: rtl/csa_rca_block.sv
// Combinational BLOCK-bit ripple-carry adder built from a chain of full
// adders. Used as block 0 of the carry-select adder and as each of the
// two candidate adders of every upper block.
module csa_rca_block
    import csa_pkg::*;
#(
    parameter int BLOCK = CSA_BLOCK_DEF
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    // carry_s[i] is the carry into bit i; carry_s[BLOCK] leaves the block
    logic [BLOCK:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < BLOCK; i++) begin : g_fa
        assign s[i]         = fa_sum(a[i], b[i], carry_s[i]);
        assign carry_s[i+1] = fa_carry(a[i], b[i], carry_s[i]);
    end

    assign cout = carry_s[BLOCK];

endmodule

// File: rtl/carry_select_adder.sv
// Registered WIDTH-bit carry-select adder.
//   Block 0 ripples from cin0. Every upper block precomputes a sum under
//   carry hypothesis cin0 and under cin1; the carry-out of the block below
//   picks one. Sum, carry-out and a valid flag are registered, giving a
//   one-cycle latency from an in_valid edge.
// Optional build macro: CSA_OVF_EN adds a registered two's-complement
// overflow output (ovf). Without it the port and its logic are absent.
module carry_select_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH_DEF,
    parameter int BLOCK = CSA_BLOCK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin0,
    input  logic             cin1,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
`ifdef CSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = csa_num_blocks(WIDTH, BLOCK);

    // Geometry must tile the operand exactly with at least one block
    if (BLOCK < 1 || BLOCK > WIDTH) begin : g_bad_block
        $error("carry_select_adder: BLOCK (%0d) must be in 1..WIDTH (%0d)", BLOCK, WIDTH);
    end else if ((WIDTH % BLOCK) != 0) begin : g_bad_tiling
        $error("carry_select_adder: WIDTH (%0d) is not a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end

    // Combinational sum and per-block carry-outs
    logic [WIDTH-1:0] sum_s;
    logic [NBLK-1:0]  blk_carry_s;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_first
            // Lowest block has a real carry-in, so a single ripple adder suffices
            csa_rca_block #(.BLOCK(BLOCK)) u_rca (
                .a    (a[BLOCK-1:0]),
                .b    (b[BLOCK-1:0]),
                .cin  (cin0),
                .s    (sum_s[BLOCK-1:0]),
                .cout (blk_carry_s[0])
            );
        end else begin : g_sel
            logic [BLOCK-1:0] sx0_s;
            logic [BLOCK-1:0] sx1_s;
            logic             cx0_s;
            logic             cx1_s;

            // Candidate assuming the carry hypothesis cin0
            csa_rca_block #(.BLOCK(BLOCK)) u_rca_h0 (
                .a    (a[k*BLOCK +: BLOCK]),
                .b    (b[k*BLOCK +: BLOCK]),
                .cin  (cin0),
                .s    (sx0_s),
                .cout (cx0_s)
            );

            // Candidate assuming the carry hypothesis cin1
            csa_rca_block #(.BLOCK(BLOCK)) u_rca_h1 (
                .a    (a[k*BLOCK +: BLOCK]),
                .b    (b[k*BLOCK +: BLOCK]),
                .cin  (cin1),
                .s    (sx1_s),
                .cout (cx1_s)
            );

            // Carry out of the block below chooses which precomputed result is real
            assign sum_s[k*BLOCK +: BLOCK] = blk_carry_s[k-1] ? sx1_s : sx0_s;
            assign blk_carry_s[k]          = blk_carry_s[k-1] ? cx1_s : cx0_s;
        end
    end

    // Output registers and their next-state values
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic             cout_q;
    logic             cout_d;
    logic             valid_q;
    logic             valid_d;

    // Capture a new result on valid input, otherwise hold; valid simply follows in_valid
    always_comb begin
        s_d     = s_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            s_d    = sum_s;
            cout_d = blk_carry_s[NBLK-1];
        end else begin
            s_d    = s_q;
            cout_d = cout_q;
        end
    end

    // Result and valid state; reset discards any pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

`ifdef CSA_OVF_EN
    logic ovf_q;
    logic ovf_d;
    logic ovf_s;

    // Like-signed operands producing a sum of the opposite sign overflowed
    assign ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);

    // Overflow flag is captured and held exactly like the sum it describes
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = ovf_s;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench for carry_select_adder. Two instances are driven:
// WIDTH=8/BLOCK=4 for directed work and WIDTH=16/BLOCK=4 alongside it for
// the random run. Define CSA_OVF_EN to also exercise the overflow output.
module tb_carry_select_adder;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin0     = 1'b0;
    logic        cin1     = 1'b1;
    logic [7:0]  a8       = 8'h00;
    logic [7:0]  b8       = 8'h00;
    logic [15:0] a16      = 16'h0000;
    logic [15:0] b16      = 16'h0000;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        cout8;
    logic        cout16;
    logic        ov8;
    logic        ov16;
`ifdef CSA_OVF_EN
    logic        ovf8;
    logic        ovf16;
`endif

    int checks = 0;
    int errors = 0;

    // Directed vectors with cin0=0, cin1=1
    logic [7:0] dir_a [9] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'hFF, 8'h0F, 8'hAA, 8'hF0, 8'h55};
    logic [7:0] dir_b [9] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h01, 8'h55, 8'h0F, 8'hAA};
    logic [7:0] dir_s [9] = '{8'h00, 8'h02, 8'h81, 8'h00, 8'hFE, 8'h10, 8'hFF, 8'hFF, 8'hFF};
    logic       dir_c [9] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};

    always #5 clk = ~clk;

    carry_select_adder #(.WIDTH(8), .BLOCK(4)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .cin0      (cin0),
        .cin1      (cin1),
        .s         (s8),
        .cout      (cout8),
        .out_valid (ov8)
`ifdef CSA_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    carry_select_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a16),
        .b         (b16),
        .cin0      (cin0),
        .cin1      (cin1),
        .s         (s16),
        .cout      (cout16),
        .out_valid (ov16)
`ifdef CSA_OVF_EN
        ,
        .ovf       (ovf16)
`endif
    );

    // Block-by-block reference: block 0 adds cin0; every upper block adds
    // cin1 if the block below carried out, else cin0. Returns {cout, sum}.
    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic c0, input logic c1,
                                            input int width, input int block);
        logic [16:0] r;
        logic [31:0] ak;
        logic [31:0] bk;
        logic [31:0] t;
        logic [31:0] mask;
        logic        c;
        r    = '0;
        c    = c0;
        mask = (32'd1 << block) - 32'd1;
        for (int k = 0; k < width / block; k++) begin
            ak = (32'(a) >> (k * block)) & mask;
            bk = (32'(b) >> (k * block)) & mask;
            t  = ak + bk + ((k == 0) ? 32'(c0) : (c ? 32'(c1) : 32'(c0)));
            r  = r | (17'(t & mask) << (k * block));
            c  = t[block];
        end
        r = r | (17'(c) << width);
        return r;
    endfunction

    // Signed-range overflow of an 8- or 16-bit two's-complement addition
    function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input int width);
        int sa;
        int sb;
        int sum;
        sa  = (a[width-1]) ? int'(a) - (1 << width) : int'(a);
        sb  = (b[width-1]) ? int'(b) - (1 << width) : int'(b);
        sum = sa + sb;
        return (sum > ((1 << (width - 1)) - 1)) || (sum < -(1 << (width - 1)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cout8, s8, ov8} !== 10'b0) begin
            errors++;
            $display("FAIL reset_initial: got cout=%b s=%h valid=%b, expected 0/00/0", cout8, s8, ov8);
        end
        for (int i = 0; i < 4; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            in_valid = 1'b1;
            step();
            checks++;
            if ({cout8, s8, ov8} !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold: got cout=%b s=%h valid=%b, expected 0/00/0", cout8, s8, ov8);
            end
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            step();
            checks++;
            if ({cout8, s8, ov8} !== 10'b0) begin
                errors++;
                $display("FAIL reset_release: got cout=%b s=%h valid=%b, expected 0/00/0", cout8, s8, ov8);
            end
        end
    endtask

    task automatic test_directed();
        cin0 = 1'b0;
        cin1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a8 = dir_a[i];
            b8 = dir_b[i];
            in_valid = 1'b1;
            step();
            checks++;
            if ({ov8, cout8, s8} !== {1'b1, dir_c[i], dir_s[i]}) begin
                errors++;
                $display("FAIL directed_%h_%h: got valid=%b cout=%b s=%h, expected 1/%b/%h",
                         dir_a[i], dir_b[i], ov8, cout8, s8, dir_c[i], dir_s[i]);
            end
        end
    endtask

    task automatic test_valid_hold();
        a8 = 8'h12;
        b8 = 8'h34;
        in_valid = 1'b1;
        step();
        checks++;
        if ({ov8, cout8, s8} !== {1'b1, 1'b0, 8'h46}) begin
            errors++;
            $display("FAIL valid_pulse: got valid=%b cout=%b s=%h, expected 1/0/46", ov8, cout8, s8);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            step();
            checks++;
            if ({ov8, cout8, s8} !== {1'b0, 1'b0, 8'h46}) begin
                errors++;
                $display("FAIL valid_hold: got valid=%b cout=%b s=%h, expected 0/0/46", ov8, cout8, s8);
            end
        end
    endtask

    task automatic test_async_reset();
        a8 = 8'hFF;
        b8 = 8'hFF;
        in_valid = 1'b1;
        step();
        checks++;
        if ({ov8, cout8, s8} !== {1'b1, 1'b1, 8'hFE}) begin
            errors++;
            $display("FAIL async_pre: got valid=%b cout=%b s=%h, expected 1/1/FE", ov8, cout8, s8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov8, cout8, s8} !== 10'b0) begin
            errors++;
            $display("FAIL async_clear: got valid=%b cout=%b s=%h, expected 0/0/00", ov8, cout8, s8);
        end
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        checks++;
        if ({ov8, cout8, s8} !== 10'b0) begin
            errors++;
            $display("FAIL async_discard: got valid=%b cout=%b s=%h, expected 0/0/00", ov8, cout8, s8);
        end
        a8 = 8'h03;
        b8 = 8'h04;
        in_valid = 1'b1;
        step();
        checks++;
        if ({ov8, cout8, s8} !== {1'b1, 1'b0, 8'h07}) begin
            errors++;
            $display("FAIL async_first: got valid=%b cout=%b s=%h, expected 1/0/07", ov8, cout8, s8);
        end
    endtask

    task automatic test_cin_combos();
        logic [16:0] r;
        logic [1:0]  combos [3] = '{2'b11, 2'b10, 2'b00};
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 20; i++) begin
                cin0 = combos[c][1];
                cin1 = combos[c][0];
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                in_valid = 1'b1;
                r = ref_add(16'(a8), 16'(b8), cin0, cin1, 8, 4);
                step();
                checks++;
                if ({cout8, s8} !== r[8:0]) begin
                    errors++;
                    $display("FAIL cin_%b%b a=%h b=%h: got cout=%b s=%h, expected cout=%b s=%h",
                             cin0, cin1, a8, b8, cout8, s8, r[8], r[7:0]);
                end
            end
        end
        cin0 = 1'b0;
        cin1 = 1'b1;
    endtask

`ifdef CSA_OVF_EN
    task automatic test_ovf();
        logic [7:0] oa [3] = '{8'h7F, 8'h80, 8'hFF};
        logic [7:0] ob [3] = '{8'h01, 8'h80, 8'h01};
        logic [9:0] oe [3] = '{{1'b1, 1'b0, 8'h80}, {1'b1, 1'b1, 8'h00}, {1'b0, 1'b1, 8'h00}};
        cin0 = 1'b0;
        cin1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a8 = oa[i];
            b8 = ob[i];
            in_valid = 1'b1;
            step();
            checks++;
            if ({ovf8, cout8, s8} !== oe[i]) begin
                errors++;
                $display("FAIL ovf_%h_%h: got ovf=%b cout=%b s=%h, expected %b", oa[i], ob[i],
                         ovf8, cout8, s8, oe[i]);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [8:0]  exp8;
        logic [16:0] exp16;
        logic        vld;
        logic        eo8;
        logic        eo16;
        exp8  = '0;
        exp16 = '0;
        eo8   = 1'b0;
        eo16  = 1'b0;
        cin0  = 1'b0;
        cin1  = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            vld = (i == 0) || ($urandom_range(0, 9) != 0);
            in_valid = vld;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if (vld) begin
                exp8  = {1'b0, a8} + {1'b0, b8};
                exp16 = {1'b0, a16} + {1'b0, b16};
                eo8   = ref_ovf(16'(a8), 16'(b8), 8);
                eo16  = ref_ovf(a16, b16, 16);
            end
            step();
            checks++;
            if ({ov8, cout8, s8} !== {vld, exp8}) begin
                errors++;
                $display("FAIL rand8 #%0d: got valid=%b cout=%b s=%h, expected valid=%b {cout,s}=%h",
                         i, ov8, cout8, s8, vld, exp8);
            end
            checks++;
            if ({ov16, cout16, s16} !== {vld, exp16}) begin
                errors++;
                $display("FAIL rand16 #%0d: got valid=%b cout=%b s=%h, expected valid=%b {cout,s}=%h",
                         i, ov16, cout16, s16, vld, exp16);
            end
`ifdef CSA_OVF_EN
            checks++;
            if ({ovf8, ovf16} !== {eo8, eo16}) begin
                errors++;
                $display("FAIL rand_ovf #%0d: got ovf8=%b ovf16=%b, expected %b/%b", i, ovf8, ovf16, eo8, eo16);
            end
`else
            if (eo8 && eo16 && 1'b0) begin
                $display("unreachable");
            end
`endif
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_valid_hold();
        test_async_reset();
        test_cin_combos();
`ifdef CSA_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
